// File: rtl/wb_port_arbiter_pkg.sv
// Shared write-back definitions for the register-file write-port arbiter:
// the write-back record layout, the arbiter FSM state encoding and widths.
package wb_port_arbiter_pkg;

  localparam int DES_W    = 5;
  localparam int DATA_W   = 32;
  localparam int WB_REC_W = DES_W + DATA_W;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [DES_W-1:0]  des;
    logic [DATA_W-1:0] data;
  } wb_rec_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the write-back request, mul/div result, register-array write and
// hazard-visibility signals around the write-port arbiter.
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic              pipe_wb_valid;
  logic [DES_W-1:0]  pipe_wb_des;
  logic [DATA_W-1:0] pipe_wb_data;
  logic              md_valid;
  logic [DES_W-1:0]  md_des;
  logic [DATA_W-1:0] md_data;
  logic              md_ready;
  logic              wb_valid;
  logic [DES_W-1:0]  wb_des;
  logic [DATA_W-1:0] wb_data;
  logic              pipe_hold;
  logic [1:0]        buf_valid;
  logic [DES_W-1:0]  buf_des0;
  logic [DES_W-1:0]  buf_des1;

  // Arbiter side.
  modport slave (
    input  pipe_wb_valid, pipe_wb_des, pipe_wb_data,
    input  md_valid, md_des, md_data,
    output md_ready,
    output wb_valid, wb_des, wb_data,
    output pipe_hold,
    output buf_valid, buf_des0, buf_des1
  );

  // Requester side (pipeline, mul/div unit, register array, hazard logic).
  modport master (
    output pipe_wb_valid, pipe_wb_des, pipe_wb_data,
    output md_valid, md_des, md_data,
    input  md_ready,
    input  wb_valid, wb_des, wb_data,
    input  pipe_hold,
    input  buf_valid, buf_des0, buf_des1
  );

endinterface

// File: rtl/wb_fifo2.sv
// Two-entry {des, data} FIFO for pending mul/div results. Entry 0 is the head;
// entries stay packed toward the head so occupancy is always contiguous.
module wb_fifo2
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wb_rec_t          push_rec,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [1:0]       vld,
  output wb_rec_t          peek0,
  output logic [DES_W-1:0] peek1_des
);

  logic                v0_q, v1_q;
  logic [WB_REC_W-1:0] e0_q, e1_q;
  logic [1:0]          occ;
  logic                pop_ok, push_ok;

  assign occ     = {1'b0, v0_q} + {1'b0, v1_q};
  assign full    = (occ == 2'(DEPTH));
  assign empty   = (occ == 2'd0);
  // A pop on an empty FIFO or a push into a full FIFO without a pop is dropped.
  assign pop_ok  = pop && v0_q;
  assign push_ok = push && (!full || pop_ok);

  // Shift-register storage: pops move entry 1 into the head, pushes fill the
  // first free slot after any same-cycle pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      e0_q <= '0;
      e1_q <= '0;
    end else if (pop_ok && push_ok) begin
      if (v1_q) begin
        e0_q <= e1_q;
        e1_q <= push_rec;
      end else begin
        e0_q <= push_rec;
      end
    end else if (pop_ok) begin
      e0_q <= e1_q;
      v0_q <= v1_q;
      e1_q <= '0;
      v1_q <= 1'b0;
    end else if (push_ok) begin
      if (!v0_q) begin
        e0_q <= push_rec;
        v0_q <= 1'b1;
      end else begin
        e1_q <= push_rec;
        v1_q <= 1'b1;
      end
    end
  end

  assign vld       = {v1_q, v0_q};
  assign peek0     = wb_rec_t'(e0_q);
  assign peek1_des = e1_q[WB_REC_W-1 -: DES_W];

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. Pipeline write-back has priority; mul/div
// results either bypass straight to the port or wait in a 2-entry buffer. A
// wait counter forces a one-cycle pipeline hold so buffered results always
// drain. Buffered results are older than anything a flush could kill, so no
// flush input exists here.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int DEPTH    = 2
) (
  input logic            clk,
  input logic            rst_n,
  wb_port_arbiter_if.slave bus
);

  // Saturating wait-counter increment.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  arb_state_t       state_q;
  logic [CNT_W-1:0] wait_q;
  logic [CNT_W-1:0] wait_nx;
  logic             pipe_hold_q;

  logic             buf_full, buf_empty;
  logic [1:0]       buf_vld;
  wb_rec_t          head_rec;
  logic [DES_W-1:0] tail_des;
  logic [1:0]       occ_p0, occ_nx;

  logic             grant_head_p0, grant_pipe_p0, grant_md_p0, grant_any_p0;
  logic             push_p0, pop_p0, md_ready_p0;
  wb_rec_t          sel_p0, md_rec_p0;

  logic             wb_vld_p1;
  wb_rec_t          wb_rec_p1;

  assign md_rec_p0.des  = bus.md_des;
  assign md_rec_p0.data = bus.md_data;

  wb_fifo2 #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_p0),
    .push_rec  (md_rec_p0),
    .pop       (pop_p0),
    .full      (buf_full),
    .empty     (buf_empty),
    .vld       (buf_vld),
    .peek0     (head_rec),
    .peek1_des (tail_des)
  );

  // ---- p0: grant selection on current requests and buffer state ----
  // Priority: forced drain, pipeline, buffer head, mul/div bypass.
  always_comb begin
    grant_head_p0 = 1'b0;
    grant_pipe_p0 = 1'b0;
    grant_md_p0   = 1'b0;
    sel_p0        = '0;
    if (pipe_hold_q && !buf_empty) begin
      grant_head_p0 = 1'b1;
      sel_p0        = head_rec;
    end else if (bus.pipe_wb_valid) begin
      grant_pipe_p0 = 1'b1;
      sel_p0.des    = bus.pipe_wb_des;
      sel_p0.data   = bus.pipe_wb_data;
    end else if (!buf_empty) begin
      grant_head_p0 = 1'b1;
      sel_p0        = head_rec;
    end else if (bus.md_valid) begin
      grant_md_p0   = 1'b1;
      sel_p0        = md_rec_p0;
    end
  end

  assign grant_any_p0 = grant_head_p0 || grant_pipe_p0 || grant_md_p0;
  assign pop_p0       = grant_head_p0;
  // Ready is held high through reset; any push during reset is discarded.
  assign md_ready_p0  = !rst_n || !buf_full || pop_p0;
  assign push_p0      = bus.md_valid && md_ready_p0 && !grant_md_p0;

  assign occ_p0  = {1'b0, buf_vld[0]} + {1'b0, buf_vld[1]};
  assign occ_nx  = occ_p0 + {1'b0, push_p0} - {1'b0, pop_p0};
  assign wait_nx = (buf_empty || pop_p0) ? '0 : sat_inc(wait_q);

  // ---- p1: registered register-array write ----
  // Destination 0 consumes its grant slot but never writes the array.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_vld_p1 <= 1'b0;
      wb_rec_p1 <= '0;
    end else begin
      wb_vld_p1 <= grant_any_p0 && (sel_p0.des != '0);
      wb_rec_p1 <= sel_p0;
    end
  end

  // Starvation FSM with wait counter; PIPE_HOLD is high exactly while in FORCE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      pipe_hold_q <= 1'b0;
    end else begin
      wait_q <= wait_nx;
      unique case (state_q)
        ST_IDLE: begin
          if (occ_nx != 2'd0) begin
            state_q     <= ST_WAIT;
            pipe_hold_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (occ_nx == 2'd0) begin
            state_q     <= ST_IDLE;
            pipe_hold_q <= 1'b0;
          end else if (!pop_p0 && (wait_nx == CNT_W'(MAX_WAIT))) begin
            state_q     <= ST_FORCE;
            pipe_hold_q <= 1'b1;
          end
        end
        ST_FORCE: begin
          state_q     <= (occ_nx == 2'd0) ? ST_IDLE : ST_WAIT;
          pipe_hold_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          pipe_hold_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.md_ready  = md_ready_p0;
  assign bus.wb_valid  = wb_vld_p1;
  assign bus.wb_des    = wb_rec_p1.des;
  assign bus.wb_data   = wb_rec_p1.data;
  assign bus.pipe_hold = pipe_hold_q;
  assign bus.buf_valid = buf_vld;
  assign bus.buf_des0  = head_rec.des;
  assign bus.buf_des1  = tail_des;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected register-array writes are queued
// as stimulus is applied and checked in order as the write port produces them.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.MAX_WAIT(4), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int      n_vec = 0;
  int      n_err = 0;
  wb_rec_t sb[$];

  function automatic wb_rec_t mk(input int des, input int data);
    wb_rec_t r;
    r.des  = 5'(des);
    r.data = 32'(data);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and retire any register write against the scoreboard.
  task automatic tick();
    wb_rec_t e;
    @(posedge clk);
    #1;
    if (bus.wb_valid === 1'b1) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wb_des", 64'(bus.wb_des), 64'(e.des));
        chk("wb_data", 64'(bus.wb_data), 64'(e.data));
      end
    end
  endtask

  task automatic drive(input logic pv, input int pd, input int pdat,
                       input logic mv, input int mdes, input int mdat);
    bus.pipe_wb_valid = pv;
    bus.pipe_wb_des   = 5'(pd);
    bus.pipe_wb_data  = 32'(pdat);
    bus.md_valid      = mv;
    bus.md_des        = 5'(mdes);
    bus.md_data       = 32'(mdat);
    #1;
    if (mv) chk("md_valid_needs_ready", 64'(bus.md_ready), 64'd1);
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  initial begin
    int   pidx;
    logic hold;

    // Reset state
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_wb_des", 64'(bus.wb_des), 64'd0);
    chk("rst_wb_data", 64'(bus.wb_data), 64'd0);
    chk("rst_pipe_hold", 64'(bus.pipe_hold), 64'd0);
    chk("rst_buf_valid", 64'(bus.buf_valid), 64'd0);
    chk("rst_md_ready", 64'(bus.md_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Bypass: empty buffer, no pipeline request
    drive(1'b0, 0, 0, 1'b1, 5, 32'h1234);
    sb.push_back(mk(5, 32'h1234));
    tick();
    chk("byp_wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("byp_buf_valid", 64'(bus.buf_valid), 64'd0);
    idle();
    tick();
    chk("byp_drained", 64'(sb.size()), 64'd0);

    // Priority: pipeline wins, mul/div result is buffered then drains
    drive(1'b1, 3, 32'hA, 1'b1, 7, 32'hB);
    sb.push_back(mk(3, 32'hA));
    sb.push_back(mk(7, 32'hB));
    tick();
    chk("pri_buf_valid", 64'(bus.buf_valid), 64'd1);
    chk("pri_buf_des0", 64'(bus.buf_des0), 64'd7);
    idle();
    tick();
    chk("pri_second_valid", 64'(bus.wb_valid), 64'd1);
    chk("pri_buf_empty", 64'(bus.buf_valid), 64'd0);
    tick();
    chk("pri_drained", 64'(sb.size()), 64'd0);

    // Starvation: pipeline requests every cycle; hold expected 5 cycles after push
    for (int i = 0; i < 5; i++) sb.push_back(mk(10 + i, 32'h100 + i));
    sb.push_back(mk(9, 32'h900));
    sb.push_back(mk(15, 32'h105));
    sb.push_back(mk(16, 32'h106));
    pidx = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 10 + pidx, 32'h100 + pidx, c == 0, 9, 32'h900);
      hold = bus.pipe_hold;
      chk($sformatf("starve_hold_c%0d", c), 64'(hold), 64'(c == 5));
      if (!hold) pidx++;
      tick();
    end
    idle();
    tick();
    tick();
    chk("starve_drained", 64'(sb.size()), 64'd0);
    chk("starve_buf_empty", 64'(bus.buf_valid), 64'd0);
    chk("starve_hold_low", 64'(bus.pipe_hold), 64'd0);

    // Full buffer, then simultaneous pop and push on a full buffer
    sb.push_back(mk(1, 32'h11));
    sb.push_back(mk(2, 32'h12));
    sb.push_back(mk(3, 32'h13));
    sb.push_back(mk(20, 32'h2000));
    sb.push_back(mk(21, 32'h2100));
    sb.push_back(mk(22, 32'h2200));
    drive(1'b1, 1, 32'h11, 1'b1, 20, 32'h2000);
    tick();
    chk("full_buf_valid_1", 64'(bus.buf_valid), 64'd1);
    drive(1'b1, 2, 32'h12, 1'b1, 21, 32'h2100);
    tick();
    chk("full_buf_valid_2", 64'(bus.buf_valid), 64'd3);
    chk("full_buf_des0", 64'(bus.buf_des0), 64'd20);
    chk("full_buf_des1", 64'(bus.buf_des1), 64'd21);
    drive(1'b1, 3, 32'h13, 1'b0, 0, 0);
    chk("full_md_ready_low", 64'(bus.md_ready), 64'd0);
    chk("full_hold_low", 64'(bus.pipe_hold), 64'd0);
    tick();
    drive(1'b0, 0, 0, 1'b1, 22, 32'h2200);
    chk("full_md_ready_on_pop", 64'(bus.md_ready), 64'd1);
    tick();
    chk("full_pp_buf_valid", 64'(bus.buf_valid), 64'd3);
    chk("full_pp_buf_des0", 64'(bus.buf_des0), 64'd21);
    chk("full_pp_buf_des1", 64'(bus.buf_des1), 64'd22);
    idle();
    tick();
    tick();
    tick();
    chk("full_drained", 64'(sb.size()), 64'd0);
    chk("full_buf_empty", 64'(bus.buf_valid), 64'd0);

    // Destination x0: occupies a slot, pops, never writes
    drive(1'b1, 2, 32'h22, 1'b1, 0, 32'hDEAD);
    sb.push_back(mk(2, 32'h22));
    tick();
    chk("x0_buffered", 64'(bus.buf_valid), 64'd1);
    idle();
    tick();
    chk("x0_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("x0_popped", 64'(bus.buf_valid), 64'd0);
    tick();
    chk("x0_drained", 64'(sb.size()), 64'd0);

    // Reset while in FORCE with two buffered entries
    for (int i = 0; i < 5; i++) sb.push_back(mk(26 + i, 32'h300 + i));
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 26 + c, 32'h300 + c, c < 2, 24 + c, 32'h400 + c);
      chk($sformatf("frc_hold_c%0d", c), 64'(bus.pipe_hold), 64'd0);
      tick();
    end
    drive(1'b1, 31, 32'h305, 1'b0, 0, 0);
    chk("frc_hold_high", 64'(bus.pipe_hold), 64'd1);
    chk("frc_buf_full", 64'(bus.buf_valid), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("frc_md_ready_in_rst", 64'(bus.md_ready), 64'd1);
    tick();
    chk("frc_rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("frc_rst_wb_des", 64'(bus.wb_des), 64'd0);
    chk("frc_rst_wb_data", 64'(bus.wb_data), 64'd0);
    chk("frc_rst_hold", 64'(bus.pipe_hold), 64'd0);
    chk("frc_rst_buf_valid", 64'(bus.buf_valid), 64'd0);
    chk("frc_rst_buf_des0", 64'(bus.buf_des0), 64'd0);
    chk("frc_rst_buf_des1", 64'(bus.buf_des1), 64'd0);
    chk("frc_rst_md_ready", 64'(bus.md_ready), 64'd1);
    idle();
    rst_n = 1'b1;
    tick();
    chk("frc_after_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("frc_after_md_ready", 64'(bus.md_ready), 64'd1);
    chk("frc_all_retired", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
